mul_div_unit: RTL

Iterative 64-bit multiply/divide unit sitting beside the ALU in the execute stage. Consumes the two read ports of the 32 x 64 register file as operands and returns its result through the register file write port (data, address, write). Runs multi-cycle with a start/busy handshake, so the pipeline issues one long op and stalls on `busy`. Destination 31 is the hard-wired zero register (XZR) and is never written.

---
 rtl/mul_div_pkg.sv | 29 ++
 rtl/mul_div_iter.sv | 73 +++++++
 rtl/mul_div_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative multiply/divide unit.
package mul_div_pkg;

  localparam int unsigned WIDTH      = 64;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned ITERATIONS = 64;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  localparam logic [ADDR_W-1:0] XZR_ADDR   = ADDR_W'(31);
  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WB
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value);
    return value[WIDTH-1] ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// 128-bit shift-add / restoring-divide step register; one iteration per asserted step.
// Divide step present only when MUL_DIV_UNIT_DIVIDER_EN is defined.
module mul_div_iter
  import mul_div_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               divide,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d, mul_next;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     sum;

  // Multiply: add multiplicand to the upper half when the current multiplier bit is set,
  // then shift right with the carry entering bit 127.
  always_comb begin
    sum      = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q})
                        : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_next = {sum, acc_q[WIDTH-1:1]};
  end

`ifdef MUL_DIV_UNIT_DIVIDER_EN
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   diff;
  logic               fits;

  // Divide: remainder lives in the upper half, quotient bits shift into the lower half.
  // A fitting subtraction always leaves a value below the divisor, so WIDTH bits suffice.
  always_comb begin
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    fits      = rem_shift >= {1'b0, b_q};
    diff      = rem_shift[WIDTH-1:0] - b_q;
    div_next  = fits ? {diff, acc_q[WIDTH-2:0], 1'b1}
                     : {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end
`endif

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, load_a};
`ifdef MUL_DIV_UNIT_DIVIDER_EN
    end else if (step) begin
      acc_d = divide ? div_next : mul_next;
`else
    end else if (step && !divide) begin
      acc_d = mul_next;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        b_q <= load_b;
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 64-bit MUL/UMULH/UDIV/SDIV unit with start/busy handshake and register-file writeback.
// Divider datapath included only when MUL_DIV_UNIT_DIVIDER_EN is defined.
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wb_ready,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  wb_data,
  output logic [ADDR_W-1:0] wb_address,
  output logic              wb_write
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  op_t                op_q;
  logic [ADDR_W-1:0]  dest_q;
  logic               accept, load, step, is_div, skip_run, to_xzr;
  logic [WIDTH-1:0]   load_a, load_b;
  logic [2*WIDTH-1:0] acc;

  assign accept = (state_q == S_IDLE) && start;
  assign is_div = (op_q == OP_UDIV) || (op_q == OP_SDIV);
  assign to_xzr = (dest_q == XZR_ADDR);

`ifdef MUL_DIV_UNIT_DIVIDER_EN
  logic signed_op, neg_q, div_zero_q;

  // SDIV divides magnitudes; the quotient sign is restored at writeback.
  assign signed_op = (op_t'(op) == OP_SDIV);
  assign load_a    = signed_op ? magnitude(operand_a) : operand_a;
  assign load_b    = signed_op ? magnitude(operand_b) : operand_b;
  assign skip_run  = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      neg_q      <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      div_zero_q <= (operand_b == '0);
    end
  end
`else
  assign load_a   = operand_a;
  assign load_b   = operand_b;
  // Without a divider, divide ops spend a single cycle in RUN before writing back zero.
  assign skip_run = is_div;
`endif

  assign load = accept;
  assign step = (state_q == S_RUN);

  mul_div_iter u_iter (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .divide (is_div),
    .load_a (load_a),
    .load_b (load_b),
    .acc    (acc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= OP_MUL;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q <= '0;
        op_q    <= op_t'(op);
        dest_q  <= dest;
      end else if (state_q == S_RUN) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((count_q == LAST_COUNT) || skip_run) state_d = S_WB;
      S_WB:    if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign wb_write   = (state_q == S_WB) && !to_xzr;
  assign done       = (state_q == S_WB) && (wb_ready || to_xzr);
  assign wb_address = dest_q;

  always_comb begin
    wb_data = acc[WIDTH-1:0];
    case (op_q)
      OP_MUL:   wb_data = acc[WIDTH-1:0];
      OP_UMULH: wb_data = acc[2*WIDTH-1:WIDTH];
      default: begin
`ifdef MUL_DIV_UNIT_DIVIDER_EN
        if (div_zero_q) begin
          wb_data = '0;
        end else begin
          wb_data = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        end
`else
        wb_data = '0;
`endif
      end
    endcase
  end

endmodule
